// File: rtl/sha_hash.sv
// SHA-256 compression engine.
// Accepts one 512-bit padded block per request and runs 64 rounds, one per
// clock. The intermediate hash is chained across blocks of one message, and
// the digest is flagged with a one-cycle Valid pulse after the final block.
module sha_hash #(
    parameter int Nb = 512,
    parameter int Nw = 32,
    parameter int Nm = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [Nb-1:0] Data,
    input  logic [Nm-1:0] Index,
    input  logic          Ready,
    input  logic          Last,
    output logic          Busy,
    output logic [255:0]  Hash,
    output logic          Valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constant ROM, indexed by the round counter.
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // SHA-256 mixing functions (rotations written as fixed bit slices).
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        big_sigma0 = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        big_sigma1 = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        small_sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        small_sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [5:0]  t_r;
    logic        last_r;
    logic        busy_r;
    logic        valid_r;
    logic [31:0] h_r  [0:7];   // chained hash H0..H7
    logic [31:0] wv_r [0:7];   // working variables a..h
    logic [31:0] w_r  [0:15];  // message schedule window, slot 0 = W[t]

    logic [31:0] t1_s;
    logic [31:0] t2_s;
    logic [31:0] new_w_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: accept in IDLE, 64 rounds, then one FINAL fold.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Ready) begin
                    next_state_s = ST_ROUND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (t_r == 6'd63) begin
                    next_state_s = ST_FINAL;
                end else begin
                    next_state_s = ST_ROUND;
                end
            end
            ST_FINAL: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // One compression round plus the schedule word 16 slots ahead of W[t].
    always_comb begin
        t1_s = wv_r[7] + big_sigma1(wv_r[4]) + ((wv_r[4] & wv_r[5]) ^ (~wv_r[4] & wv_r[6]))
             + K[t_r] + w_r[0];
        t2_s = big_sigma0(wv_r[0])
             + ((wv_r[0] & wv_r[1]) ^ (wv_r[0] & wv_r[2]) ^ (wv_r[1] & wv_r[2]));
        new_w_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    end

    // Registered status outputs: Busy tracks the upcoming state, Valid follows FINAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r  <= (next_state_s != ST_IDLE);
            valid_r <= (state_r == ST_FINAL) ? last_r : 1'b0;
        end
    end

    // Datapath: block load on accept, round update, and final hash fold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r    <= 6'd0;
            last_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_r[i]  <= IV[i];
                wv_r[i] <= IV[i];
            end
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= 32'h00000000;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Ready) begin
                        t_r    <= 6'd0;
                        last_r <= Last;
                        // Words arrive little-endian byte order; SHA wants big-endian.
                        for (int i = 0; i < 16; i++) begin
                            w_r[i] <= {Data[i*Nw +: 8], Data[i*Nw+8 +: 8],
                                       Data[i*Nw+16 +: 8], Data[i*Nw+24 +: 8]};
                        end
                        // Index 0 starts a new message: restart from the IV.
                        if (Index == {Nm{1'b0}}) begin
                            for (int i = 0; i < 8; i++) begin
                                h_r[i]  <= IV[i];
                                wv_r[i] <= IV[i];
                            end
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                wv_r[i] <= h_r[i];
                            end
                        end
                    end else begin
                        t_r <= t_r;
                    end
                end
                ST_ROUND: begin
                    wv_r[7] <= wv_r[6];
                    wv_r[6] <= wv_r[5];
                    wv_r[5] <= wv_r[4];
                    wv_r[4] <= wv_r[3] + t1_s;
                    wv_r[3] <= wv_r[2];
                    wv_r[2] <= wv_r[1];
                    wv_r[1] <= wv_r[0];
                    wv_r[0] <= t1_s + t2_s;
                    for (int i = 0; i < 15; i++) begin
                        w_r[i] <= w_r[i+1];
                    end
                    w_r[15] <= new_w_s;
                    t_r     <= t_r + 6'd1;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        h_r[i] <= h_r[i] + wv_r[i];
                    end
                end
                default: begin
                    t_r <= 6'd0;
                end
            endcase
        end
    end

    assign Busy  = busy_r;
    assign Valid = valid_r;
    assign Hash  = {h_r[0], h_r[1], h_r[2], h_r[3], h_r[4], h_r[5], h_r[6], h_r[7]};

endmodule

// File: tb/tb_sha_hash.sv
// Directed bench for sha_hash: table of known-answer blocks plus hand-written
// sequences for back-to-back accept, ignored Ready while busy, and mid-block reset.
module tb_sha_hash;

    logic         clk;
    logic         rst;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic         Ready;
    logic         Last;
    logic         Busy;
    logic [255:0] Hash;
    logic         Valid;

    int n_vec;
    int n_err;

    localparam logic [255:0] IV_HASH =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_HASH =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_HASH =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_HASH =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] ABC_BLK   = {32'h18000000, 448'h0, 32'h80636261};
    localparam logic [511:0] EMPTY_BLK = {480'h0, 32'h00000080};
    localparam logic [511:0] TWO_BLK0  = {32'h00000000, 32'h00000080,
        32'h71706f6e, 32'h706f6e6d, 32'h6f6e6d6c, 32'h6e6d6c6b,
        32'h6d6c6b6a, 32'h6c6b6a69, 32'h6b6a6968, 32'h6a696867,
        32'h69686766, 32'h68676665, 32'h67666564, 32'h66656463,
        32'h65646362, 32'h64636261};
    localparam logic [511:0] TWO_BLK1  = {32'hc0010000, 480'h0};

    typedef struct {
        logic [511:0] data;
        logic [63:0]  index;
        logic         last;
        logic         exp_valid;
        logic [255:0] exp_hash;
    } vec_t;

    vec_t vecs [0:4];

    sha_hash dut (
        .clk   (clk),
        .rst   (rst),
        .Data  (Data),
        .Index (Index),
        .Ready (Ready),
        .Last  (Last),
        .Busy  (Busy),
        .Hash  (Hash),
        .Valid (Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a block for one clock, then drop Ready; returns at the negedge after accept.
    task automatic drive_block(input logic [511:0] d, input logic [63:0] idx, input logic l);
        Data  = d;
        Index = idx;
        Last  = l;
        Ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Ready = 1'b0;
        check("busy_after_accept", {255'd0, Busy}, 256'd1);
    endtask

    // Count busy cycles until Busy falls (bounded); returns at that negedge.
    task automatic wait_done(input int start, output int cycles);
        cycles = start;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!Busy) break;
            cycles++;
        end
    endtask

    int  cyc;
    logic seen;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        Ready = 1'b0;
        Data  = 512'd0;
        Index = 64'd0;
        Last  = 1'b0;

        vecs[0] = '{ABC_BLK,   64'd0, 1'b1, 1'b1, ABC_HASH};
        vecs[1] = '{EMPTY_BLK, 64'd0, 1'b1, 1'b1, EMPTY_HASH};
        vecs[2] = '{TWO_BLK0,  64'd0, 1'b0, 1'b0, 256'd0};
        vecs[3] = '{TWO_BLK1,  64'd1, 1'b1, 1'b1, TWO_HASH};
        vecs[4] = '{ABC_BLK,   64'd0, 1'b1, 1'b1, ABC_HASH};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy",  {255'd0, Busy},  256'd0);
        check("reset_valid", {255'd0, Valid}, 256'd0);
        check("reset_hash",  Hash, IV_HASH);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven known-answer blocks
        for (int i = 0; i < 5; i++) begin
            drive_block(vecs[i].data, vecs[i].index, vecs[i].last);
            wait_done(1, cyc);
            check("busy_cycles", 256'(cyc), 256'd65);
            check("valid", {255'd0, Valid}, {255'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) check("digest", Hash, vecs[i].exp_hash);
            @(negedge clk);
            check("valid_one_cycle", {255'd0, Valid}, 256'd0);
            check("idle_busy", {255'd0, Busy}, 256'd0);
        end

        // Back-to-back: new abc message accepted in the Valid cycle of the empty message
        drive_block(EMPTY_BLK, 64'd0, 1'b1);
        wait_done(1, cyc);
        check("b2b_first_valid", {255'd0, Valid}, 256'd1);
        check("b2b_first_hash", Hash, EMPTY_HASH);
        drive_block(ABC_BLK, 64'd0, 1'b1);
        check("b2b_valid_dropped", {255'd0, Valid}, 256'd0);
        wait_done(1, cyc);
        check("b2b_cycles", 256'(cyc), 256'd65);
        check("b2b_valid", {255'd0, Valid}, 256'd1);
        check("b2b_hash", Hash, ABC_HASH);
        @(negedge clk);

        // Backpressure: Ready with different data while busy must be ignored
        drive_block(ABC_BLK, 64'd0, 1'b1);
        repeat (10) @(negedge clk);
        Data  = EMPTY_BLK;
        Ready = 1'b1;
        repeat (3) @(negedge clk);
        Ready = 1'b0;
        Data  = ABC_BLK;
        wait_done(14, cyc);
        check("bp_cycles", 256'(cyc), 256'd65);
        check("bp_valid", {255'd0, Valid}, 256'd1);
        check("bp_hash", Hash, ABC_HASH);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (Busy || Valid) seen = 1'b1;
        end
        check("bp_not_queued", {255'd0, seen}, 256'd0);

        // Reset at round 30
        drive_block(ABC_BLK, 64'd0, 1'b1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy",  {255'd0, Busy},  256'd0);
        check("midrst_valid", {255'd0, Valid}, 256'd0);
        check("midrst_hash",  Hash, IV_HASH);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (Busy || Valid) seen = 1'b1;
        end
        check("midrst_no_valid", {255'd0, seen}, 256'd0);
        drive_block(ABC_BLK, 64'd0, 1'b1);
        wait_done(1, cyc);
        check("postrst_cycles", 256'(cyc), 256'd65);
        check("postrst_valid", {255'd0, Valid}, 256'd1);
        check("postrst_hash", Hash, ABC_HASH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
